// File: rtl/tdm_demux_1x4_pkg.sv
// Shared definitions for the 1:4 TDM demultiplexer: frame geometry and FSM encoding.
package tdm_demux_1x4_pkg;

  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux_1x4_if.sv
// TDM input stream plus rebuilt-frame outputs of the 1:4 demultiplexer.
interface tdm_demux_1x4_if #(
  parameter int W = 1
);

  logic [W-1:0] din;
  logic         din_valid;
  logic         din_sync;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic         frame_valid;
  logic         locked;
  logic         sync_err;

  // Source side: drives the TDM beats and observes the rebuilt frame.
  modport master (
    output din, din_valid, din_sync,
    input  y0, y1, y2, y3, frame_valid, locked, sync_err
  );

  // Demultiplexer side.
  modport slave (
    input  din, din_valid, din_sync,
    output y0, y1, y2, y3, frame_valid, locked, sync_err
  );

endinterface

// File: rtl/tdm_demux_1x4_ctrl.sv
// Frame-alignment FSM and slot counter; emits shadow write-enables, frame load and error pulse.
module tdm_demux_ctrl
  import tdm_demux_1x4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic                 din_sync,
  output logic [FRAME_LEN-2:0] sh_we,
  output logic                 frame_load,
  output logic                 err_pulse,
  output logic                 locked
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sh_we      = '0;
    frame_load = 1'b0;
    err_pulse  = 1'b0;

    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (din_sync) begin
            sh_we[0]  = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = LOCKED;
          end
        end

        LOCKED: begin
          if (din_sync) begin
            // Early sync drops the partial frame and restarts from slot 0.
            err_pulse = (cnt != '0);
            sh_we[0]  = 1'b1;
            cnt_nxt   = CNT_W'(1);
          end else if (cnt == '0) begin
            err_pulse = 1'b1;
            state_nxt = HUNT;
          end else if (cnt == CNT_W'(FRAME_LEN - 1)) begin
            frame_load = 1'b1;
            cnt_nxt    = '0;
          end else begin
            sh_we[cnt] = 1'b1;
            cnt_nxt    = cnt + CNT_W'(1);
          end
        end

        default: state_nxt = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer: shadows slots 0..2, then loads all four channel outputs at once.
module tdm_demux_1x4
  import tdm_demux_1x4_pkg::*;
#(
  parameter int W = 1
) (
  input logic             clk,
  input logic             rst,
  tdm_demux_1x4_if.slave  bus
);

  logic [FRAME_LEN-2:0] sh_we;
  logic                 frame_load;
  logic                 err_pulse;
  logic [W-1:0]         sh0, sh1, sh2;
  logic [W-1:0]         y0_q, y1_q, y2_q, y3_q;
  logic                 frame_valid_q;
  logic                 sync_err_q;

  tdm_demux_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (bus.din_valid),
    .din_sync   (bus.din_sync),
    .sh_we      (sh_we),
    .frame_load (frame_load),
    .err_pulse  (err_pulse),
    .locked     (bus.locked)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
    end else begin
      if (sh_we[0]) sh0 <= bus.din;
      if (sh_we[1]) sh1 <= bus.din;
      if (sh_we[2]) sh2 <= bus.din;
    end
  end

  // Outputs only move on a completed frame, so a partial frame is never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      y0_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      y3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= frame_load;
      sync_err_q    <= sync_err_q | err_pulse;
      if (frame_load) begin
        y0_q <= sh0;
        y1_q <= sh1;
        y2_q <= sh2;
        y3_q <= bus.din;
      end
    end
  end

  assign bus.y0          = y0_q;
  assign bus.y1          = y1_q;
  assign bus.y2          = y2_q;
  assign bus.y3          = y3_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Self-checking bench for tdm_demux_1x4 (W=4): directed scenarios plus random traffic vs a queue model.
module tb_tdm_demux_1x4;

  localparam int W = 4;

  logic clk;
  logic rst;

  tdm_demux_1x4_if #(.W(W)) bus ();

  tdm_demux_1x4 #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame is the list of beats collected since the last accepted sync.
  logic [W-1:0] m_y [4];
  logic [W-1:0] m_part [$];
  bit           m_fv;
  bit           m_locked;
  bit           m_err;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    m_fv = 1'b0;
    if (r) begin
      foreach (m_y[i]) m_y[i] = '0;
      m_part.delete();
      m_locked = 1'b0;
      m_err    = 1'b0;
    end else if (v) begin
      if (s) begin
        if (m_locked && m_part.size() != 0) m_err = 1'b1;
        m_part.delete();
        m_part.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_part.size() == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_part.push_back(d);
          if (m_part.size() == 4) begin
            for (int i = 0; i < 4; i++) m_y[i] = m_part[i];
            m_fv = 1'b1;
            m_part.delete();
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("y0",          bus.y0,                  m_y[0]);
    check("y1",          bus.y1,                  m_y[1]);
    check("y2",          bus.y2,                  m_y[2]);
    check("y3",          bus.y3,                  m_y[3]);
    check("frame_valid", W'(bus.frame_valid),     W'(m_fv));
    check("locked",      W'(bus.locked),          W'(m_locked));
    check("sync_err",    W'(bus.sync_err),        W'(m_err));
  endtask

  // One clock cycle: drive on the falling edge, update the model at the rising edge, check 1 ns later.
  task automatic cycle(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    @(negedge clk);
    rst           = r;
    bus.din_valid = v;
    bus.din_sync  = s;
    bus.din       = d;
    @(posedge clk);
    model_step(r, v, s, d);
    #1;
    check_all();
  endtask

  task automatic beat(input bit s, input logic [W-1:0] d);
    cycle(1'b0, 1'b1, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), W'($urandom));
  endtask

  task automatic frame(input logic [W-1:0] a, b, c, d);
    beat(1'b1, a);
    beat(1'b0, b);
    beat(1'b0, c);
    beat(1'b0, d);
  endtask

  task automatic expect_y(input string tag, input logic [W-1:0] a, b, c, d);
    check({tag, "_y0"}, bus.y0, a);
    check({tag, "_y1"}, bus.y1, b);
    check({tag, "_y2"}, bus.y2, c);
    check({tag, "_y3"}, bus.y3, d);
  endtask

  initial begin
    rst           = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.din_sync  = 1'b0;
    m_fv = 1'b0; m_locked = 1'b0; m_err = 1'b0;
    foreach (m_y[i]) m_y[i] = '0;

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("rst_fv", W'(bus.frame_valid), '0);
    idle(1);

    // Clean frame on consecutive cycles.
    frame(4'hA, 4'hB, 4'hC, 4'hD);
    check("clean_fv", W'(bus.frame_valid), W'(1));
    expect_y("clean", 4'hA, 4'hB, 4'hC, 4'hD);
    idle(1);
    check("clean_fv_drop", W'(bus.frame_valid), '0);

    // Same frame with two-cycle gaps; frame_valid only after the last beat.
    beat(1'b1, 4'hA); idle(2);
    beat(1'b0, 4'hB); idle(2);
    beat(1'b0, 4'hC); idle(2);
    beat(1'b0, 4'hD);
    check("gap_fv", W'(bus.frame_valid), W'(1));
    idle(2);

    // Pre-sync garbage while hunting after a reset.
    cycle(1'b1, 1'b0, 1'b0, '0);
    beat(1'b0, 4'h5);
    beat(1'b0, 4'h6);
    frame(4'h1, 4'h2, 4'h3, 4'h4);
    expect_y("hunt", 4'h1, 4'h2, 4'h3, 4'h4);
    check("hunt_err", W'(bus.sync_err), '0);

    // Early sync.
    beat(1'b1, 4'h1);
    beat(1'b0, 4'h2);
    beat(1'b1, 4'h9);
    check("early_err", W'(bus.sync_err), W'(1));
    beat(1'b0, 4'hA);
    beat(1'b0, 4'hB);
    beat(1'b0, 4'hC);
    expect_y("early", 4'h9, 4'hA, 4'hB, 4'hC);
    idle(3);
    check("early_sticky", W'(bus.sync_err), W'(1));

    // Missing sync after a full frame.
    cycle(1'b1, 1'b0, 1'b0, '0);
    frame(4'hE, 4'hF, 4'h0, 4'h8);
    beat(1'b0, 4'h7);
    check("miss_locked", W'(bus.locked), '0);
    check("miss_err",    W'(bus.sync_err), W'(1));
    expect_y("miss_hold", 4'hE, 4'hF, 4'h0, 4'h8);
    frame(4'h1, 4'h2, 4'h3, 4'h4);
    expect_y("relock", 4'h1, 4'h2, 4'h3, 4'h4);

    // Back-to-back frames, reset after beat 2 of the third frame.
    cycle(1'b1, 1'b0, 1'b0, '0);
    frame(4'h3, 4'h5, 4'h7, 4'h9);
    frame(4'h2, 4'h4, 4'h6, 4'h8);
    beat(1'b1, 4'hC);
    beat(1'b0, 4'hD);
    cycle(1'b1, 1'b1, 1'b0, 4'hE);
    expect_y("rst_mid", '0, '0, '0, '0);
    beat(1'b0, 4'hE);
    beat(1'b0, 4'hF);
    check("rst_mid_locked", W'(bus.locked), '0);
    frame(4'h6, 4'h7, 4'h8, 4'h9);

    // Random traffic: mostly well-formed frames with occasional sync faults, gaps and resets.
    begin
      int slot = 0;
      for (int n = 0; n < 600; n++) begin
        bit r, v, s;
        r = ($urandom_range(0, 99) == 0);
        v = ($urandom_range(0, 3) != 0);
        s = (slot == 0);
        if ($urandom_range(0, 11) == 0) s = ~s;
        cycle(r, v, s, W'($urandom));
        if (v && !r) slot = s ? 1 : (slot + 1) % 4;
        if (r) slot = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive-side counterpart of the 4:1 channel multiplexer.
- Takes a single time-division-multiplexed stream (4 channel slots per frame, slot 0 flagged by a sync strobe) and rebuilds the frame.
- Routes each beat to its channel and presents all four channels as registered, frame-aligned parallel outputs with a one-cycle frame_valid strobe.
- Sits after the link/serial front end and feeds per-channel consumers.

Parameters:
- W, 1, data width of each channel slot (bits).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  W  TDM data beat.
- din_valid  input  1  din is a valid beat this cycle.
- din_sync  input  1  this valid beat is slot 0 (channel i0) of a frame; ignored when din_valid=0.
- y0  output  W  channel 0 of the last complete frame (registered).
- y1  output  W  channel 1 of the last complete frame (registered).
- y2  output  W  channel 2 of the last complete frame (registered).
- y3  output  W  channel 3 of the last complete frame (registered).
- frame_valid  output  1  one-cycle pulse; y0..y3 were updated at the current edge.
- locked  output  1  high while in state LOCKED.
- sync_err  output  1  sticky alignment-error flag; cleared only by rst.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. Sampled on the rising clk edge, it overrides every other input.
- Reset values:
  - y0..y3 = 0, frame_valid = 0, locked = 0, sync_err = 0.
  - State HUNT, slot counter cnt = 0, shadow registers sh0..sh2 = 0.
- Internal state:
  - cnt: 2-bit slot index, wraps 3->0.
  - sh0..sh2: W-bit shadow registers holding slots 0..2 of the frame in progress.
  - The outputs are double-buffered and never show a partial frame.
- Cycles with din_valid=0: state, cnt and shadows hold; frame_valid=0. din_sync is don't-care.
- State HUNT:
  - Valid beat with sync=0: discarded; stay in HUNT.
  - Valid beat with sync=1: sh0<=din, cnt<=1, go to LOCKED.
- State LOCKED, valid beat:
  - sync=1, cnt=0: normal frame start. sh0<=din, cnt<=1.
  - sync=1, cnt!=0: early sync. Set sync_err=1, drop the partial frame, then sh0<=din, cnt<=1. Stay in LOCKED; frame_valid stays 0.
  - sync=0, cnt=0: missing sync. Set sync_err=1, discard the beat, go to HUNT with cnt=0.
  - sync=0, cnt=1 or 2: sh[cnt]<=din, cnt<=cnt+1.
  - sync=0, cnt=3: frame complete. At the same edge: y0<=sh0, y1<=sh1, y2<=sh2, y3<=din, frame_valid<=1, cnt<=0.
- Latency:
  - y0..y3 and frame_valid change at the edge that samples the 4th valid beat. They are visible in the following cycle.
  - frame_valid is high for exactly one cycle per completed frame.
  - Gaps (din_valid=0) between beats are allowed and do not break the frame.
- Hold: y0..y3 keep the last complete frame until the next complete frame or rst. HUNT and error events do not clear them.
- Back-to-back frames: the 4th beat of frame N is followed immediately by the sync beat of frame N+1. frame_valid pulses once per frame, with no dead cycle.
- Reset mid-frame: the partial frame is lost. The next frame is only accepted after a sync beat.
- Outputs: locked = (state==LOCKED), driven from a register. sync_err never self-clears.

Decomposition:
- Shared package holds:
  - FRAME_LEN = 4.
  - CNT_W = 2.
  - State encoding: HUNT = 1'b0, LOCKED = 1'b1.
- One natural sub-module, tdm_demux_ctrl: the FSM plus cnt. It produces shadow write-enables (one-hot over sh0..sh2), a frame-complete load, and the error pulse.
- The top level holds the W-wide shadow and output registers.

Test Plan (W=4):
- Reset, then one clean frame: valid beats A(sync),B,C,D on consecutive cycles -> next cycle y0..y3=A,B,C,D, frame_valid=1 for 1 cycle, locked=1, sync_err=0.
- Same frame with din_valid=0 gaps of 2 cycles between each beat -> identical y values. frame_valid pulses once, only after beat D.
- Pre-sync garbage: valid beats 5,6 (sync=0) while in HUNT, then 1(sync),2,3,4 -> y=1,2,3,4. sync_err stays 0 (HUNT discards are not errors).
- Early sync: 1(sync),2, then 9(sync),A,B,C -> no frame_valid for the partial frame; y=9,A,B,C; sync_err=1 and stays 1.
- Missing sync: a full frame, then 7(sync=0) at cnt=0 -> locked drops next cycle, sync_err=1, y holds the prior frame. A following 1(sync),2,3,4 relocks, giving y=1,2,3,4.
- Back-to-back frames with rst asserted after beat 2 of the 3rd frame -> all outputs return to 0 next cycle. Beats without sync are then ignored until the next sync.
